// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the FP arithmetic unit: field widths, special
// encodings and the divider sequencing states.
package fp_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        ROUND,
        DONE
    } divState_t;

endpackage

// File: rtl/fp_unpack.sv
// Splits one FP32 operand into sign, biased exponent and 24-bit mantissa with
// the hidden bit restored; denormals are flushed to a signed zero.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       op_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              zero_o,
    output logic              inf_o,
    output logic              nan_o
);

    logic [EXP_W-1:0]  expField;
    logic [FRAC_W-1:0] fracField;

    assign sign_o    = op_i[31];
    assign expField  = op_i[30:23];
    assign fracField = op_i[FRAC_W-1:0];

    // A zero exponent field covers both true zero and denormals, which are flushed.
    assign zero_o = (expField == '0);
    assign inf_o  = (expField == '1) && (fracField == '0);
    assign nan_o  = (expField == '1) && (fracField != '0);

    assign exp_o  = expField;
    assign mant_o = zero_o ? '0 : {1'b1, fracField};

endmodule

// File: rtl/fp_div.sv
// Sequential FP32 divider: restoring mantissa division, one quotient bit per
// clock, round-to-nearest-even, fixed latency for every operand class.
module fp_div
    import fp_pkg::*;
#(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        start,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(QBITS);
    localparam logic [QBITS-1:0] LOW_MASK = (QBITS'(1) << (QBITS - 26)) - QBITS'(1);

    divState_t          state_q;
    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [MANT_W:0]    rem_q;
    logic [MANT_W-1:0]  div_q;
    logic [QBITS-1:0]   quo_q;
    logic [CW-1:0]      cnt_q;
    logic               nanRes_q, infRes_q, zeroRes_q;
    logic [31:0]        result_q;
    logic               busy_q, done_q;

    logic               signA, signB, zeroA, zeroB, infA, infB, nanA, nanB;
    logic [EXP_W-1:0]   expA, expB;
    logic [MANT_W-1:0]  mantA, mantB;

    fp_unpack unpackA (
        .op_i   (a_q),
        .sign_o (signA),
        .exp_o  (expA),
        .mant_o (mantA),
        .zero_o (zeroA),
        .inf_o  (infA),
        .nan_o  (nanA)
    );

    fp_unpack unpackB (
        .op_i   (b_q),
        .sign_o (signB),
        .exp_o  (expB),
        .mant_o (mantB),
        .zero_o (zeroB),
        .inf_o  (infB),
        .nan_o  (nanB)
    );

    logic signed [9:0] expStart;
    assign expStart = $signed({2'b00, expA}) - $signed({2'b00, expB}) + $signed(10'(EXP_BIAS));

    // Restoring step: the remainder stays below 2*divisor, so 26 bits hold the trial.
    logic [MANT_W+1:0] trial;
    logic              qBit;
    logic [MANT_W:0]   remKeep;
    assign trial   = {1'b0, rem_q} - {2'b00, div_q};
    assign qBit    = ~trial[MANT_W+1];
    assign remKeep = qBit ? trial[MANT_W:0] : rem_q;

    logic [MANT_W-1:0] mantTop;
    logic              guardBit, roundBit, stickyBit, roundUp;
    logic [MANT_W:0]   mantRnd;
    logic signed [9:0] expRnd;
    logic [FRAC_W-1:0] fracRnd;
    logic [31:0]       result_d;

    always_comb begin
        mantTop   = quo_q[QBITS-1 -: MANT_W];
        guardBit  = quo_q[QBITS-MANT_W-1];
        roundBit  = quo_q[QBITS-MANT_W-2];
        stickyBit = (|rem_q) | (|(quo_q & LOW_MASK));
        roundUp   = guardBit & (roundBit | stickyBit | mantTop[0]);
        mantRnd   = {1'b0, mantTop} + {{MANT_W{1'b0}}, roundUp};
        expRnd    = mantRnd[MANT_W] ? exp_q + 10'sd1 : exp_q;
        fracRnd   = mantRnd[MANT_W] ? mantRnd[MANT_W-1:1] : mantRnd[FRAC_W-1:0];

        result_d = {sign_q, expRnd[EXP_W-1:0], fracRnd};
        if (nanRes_q)
            result_d = QNAN;
        else if (infRes_q || expRnd >= 10'sd255)
            result_d = PINF | {sign_q, 31'd0};
        else if (zeroRes_q || expRnd <= 10'sd0)
            result_d = {sign_q, 31'd0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            nanRes_q  <= 1'b0;
            infRes_q  <= 1'b0;
            zeroRes_q <= 1'b0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q    <= signA ^ signB;
                    exp_q     <= expStart;
                    rem_q     <= {1'b0, mantA};
                    div_q     <= mantB;
                    quo_q     <= '0;
                    cnt_q     <= '0;
                    nanRes_q  <= nanA | nanB | (zeroA & zeroB) | (infA & infB);
                    infRes_q  <= infA | zeroB;
                    zeroRes_q <= zeroA | infB;
                    state_q   <= DIVIDE;
                end
                DIVIDE: begin
                    rem_q <= {remKeep[MANT_W-1:0], 1'b0};
                    quo_q <= {quo_q[QBITS-2:0], qBit};
                    if (cnt_q == CW'(QBITS - 1))
                        state_q <= NORM;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                NORM: begin
                    if (!quo_q[QBITS-1]) begin
                        quo_q <= {quo_q[QBITS-2:0], 1'b0};
                        exp_q <= exp_q - 10'sd1;
                    end
                    state_q <= ROUND;
                end
                ROUND: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vectors, handshake corner cases and
// random operands compared against an exact integer-arithmetic division model.
module tb_fp_div;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic        start;
    logic [31:0] result;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    localparam int LATENCY = 29;

    fp_div dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .start  (start),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] want;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Exact quotient of the mantissas, rounded to nearest-even from the true remainder.
    function automatic logic [31:0] refDiv(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        bit          zx, zy, ix, iy, nx, ny;
        logic [63:0] ma, mb, num, m, r;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return 32'h7FC0_0000;
        if (ix || zy) return {s, 31'h7F80_0000};
        if (zx || iy) return {s, 31'h0};
        ma = {40'd0, 1'b1, x[22:0]};
        mb = {40'd0, 1'b1, y[22:0]};
        e  = ex - ey + 127;
        if (ma >= mb) begin
            num = ma << 23;
        end else begin
            num = ma << 24;
            e   = e - 1;
        end
        m = num / mb;
        r = num - m * mb;
        if ((2 * r > mb) || ((2 * r == mb) && m[0])) m = m + 1;
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 31'h7F80_0000};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] randOperand();
        int unsigned mode;
        logic [31:0] v;
        mode = $urandom_range(0, 9);
        v    = $urandom();
        case (mode)
            0: ;
            1: begin
                case ($urandom_range(0, 3))
                    0: v[30:0] = 31'd0;
                    1: v[30:23] = 8'd0;
                    2: v[30:0] = 31'h7F80_0000;
                    default: v[30:23] = 8'hFF;
                endcase
            end
            2: v[30:23] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 6)) : 8'($urandom_range(249, 254));
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Called one time unit after a rising edge with the DUT idle; returns one time
    // unit after the edge that ends the DONE cycle.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 output logic [31:0] res, output int lat);
        a     = opA;
        b     = opB;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busyAfterAccept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < LATENCY + 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("doneOnePulse", {31'd0, done}, 32'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] res, want, opA, opB;
    int          lat, pulses, doneLat;

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetResult", result, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000});
        vecs.push_back('{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB});
        vecs.push_back('{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000});
        vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000});
        vecs.push_back('{32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000});
        vecs.push_back('{32'h0080_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0100_0000});
        vecs.push_back('{32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000});
        vecs.push_back('{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000});
        vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000});
        vecs.push_back('{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000});
        vecs.push_back('{32'h4000_0000, 32'h7F80_0000, 32'h0000_0000});
        vecs.push_back('{32'h8000_0001, 32'h3F80_0000, 32'h8000_0000});
        vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h3F80_0000});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].opA, vecs[i].opB, res, lat);
            checkOutput($sformatf("vecLatency[%0d]", i), lat, LATENCY);
            checkOutput($sformatf("vecResult[%0d]", i), res, vecs[i].want);
        end

        // Second start five cycles into an operation must not disturb it.
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        pulses  = 0;
        doneLat = 0;
        res     = '0;
        for (int c = 1; c <= LATENCY + 8; c++) begin
            if (c == 5) begin
                a     = 32'h3F80_0000;
                b     = 32'h4040_0000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                pulses++;
                doneLat = c;
                res     = result;
            end
        end
        checkOutput("busyStartPulses", pulses, 1);
        checkOutput("busyStartLatency", doneLat, LATENCY);
        checkOutput("busyStartResult", res, 32'h4040_0000);

        // Start coinciding with done lands in DONE and must be ignored.
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < LATENCY + 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("doneStartLatency", lat, LATENCY);
        checkOutput("doneStartResult", result, 32'h3EAA_AAAB);
        a     = 32'h40C0_0000;
        b     = 32'h4000_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("doneStartIgnoredBusy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int c = 0; c < LATENCY + 6; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("doneStartIgnoredPulses", pulses, 0);

        // Asynchronous reset ten cycles into DIVIDE abandons the operation.
        a     = 32'h3F80_0000;
        b     = 32'h4040_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        checkOutput("midOpBusy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncResetBusy", {31'd0, busy}, 32'd0);
        checkOutput("asyncResetDone", {31'd0, done}, 32'd0);
        checkOutput("asyncResetResult", result, 32'd0);
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        rst = 1'b1;
        for (int c = 0; c < LATENCY + 6; c++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("abandonedNoDone", pulses, 0);
        applyStimulus(32'h40C0_0000, 32'h4000_0000, res, lat);
        checkOutput("afterResetLatency", lat, LATENCY);
        checkOutput("afterResetResult", res, 32'h4040_0000);

        for (int i = 0; i < 40; i++) begin
            opA  = randOperand();
            opB  = randOperand();
            want = refDiv(opA, opB);
            applyStimulus(opA, opB, res, lat);
            checkOutput($sformatf("randLatency[%0d]", i), lat, LATENCY);
            checkOutput($sformatf("randResult[%0d] %h/%h", i, opA, opB), res, want);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
